// File: rtl/ad7946_pkg.sv
// Shared AD7946 frame constants and responder state type; also imported by ad7946_controller.
package ad7946_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned DATA_W     = 14;
  localparam int unsigned LEAD_ZEROS = 2;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, PDN} state_e;

  typedef logic [DATA_W-1:0]     sample_t;
  typedef logic [FRAME_BITS-1:0] frame_t;

  function automatic frame_t make_frame(input sample_t s);
    return {{LEAD_ZEROS{1'b0}}, s};
  endfunction

endpackage

// File: rtl/ad7946_responder_if.sv
// ADC-side serial bus: controller drives strobe, clock, channel select and power-down; responder drives sdo.
interface ad7946_responder_if;
  logic cs_n;
  logic sclk;
  logic chsel;
  logic pden;
  logic sdo;

  modport master (output cs_n, output sclk, output chsel, output pden, input sdo);
  modport slave  (input cs_n, input sclk, input chsel, input pden, output sdo);
endinterface

// File: rtl/ad7946_sync.sv
// SYNC_STAGES-deep synchronizer with single-cycle rise/fall pulses on the synchronized level.
module ad7946_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/ad7946_responder.sv
// AD7946 stand-in: answers 16-bit read frames with {2'b00, sample} on sdo, MSB first.
// Define AD7946_RESP_RAMP_EN to source samples from internal per-channel ramp counters.
module ad7946_responder
  import ad7946_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RAMP_STEP   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  ad7946_responder_if.slave   bus,
  input  logic [DATA_W-1:0]   ch0_data,
  input  logic [DATA_W-1:0]   ch1_data,
  output logic                frame_done,
  output logic                frame_err
);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_fall;
  logic pden_s;
  logic chsel_s;
  logic sclk_unused_s, sclk_unused_rise, pden_unused_rise, pden_unused_fall;
  logic [SYNC_STAGES-1:0] chsel_sync_q;

  ad7946_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d_i(bus.cs_n),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  ad7946_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(bus.sclk),
    .q_o(sclk_unused_s), .rise_o(sclk_unused_rise), .fall_o(sclk_fall)
  );

  ad7946_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_pden (
    .clk(clk), .rst_n(rst_n), .d_i(bus.pden),
    .q_o(pden_s), .rise_o(pden_unused_rise), .fall_o(pden_unused_fall)
  );

  // chsel is only sampled as a level at frame start, so no edge detector
  always_ff @(posedge clk) begin
    if (!rst_n) chsel_sync_q <= '0;
    else        chsel_sync_q <= {chsel_sync_q[SYNC_STAGES-2:0], bus.chsel};
  end
  assign chsel_s = chsel_sync_q[SYNC_STAGES-1];

  state_e          state_q, state_d;
  frame_t          shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            sdo_q, sdo_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            load, complete, abort;
  sample_t         sample_sel;

`ifdef AD7946_RESP_RAMP_EN
  localparam sample_t Step = sample_t'(RAMP_STEP);
  sample_t ramp0_q, ramp0_d, ramp1_q, ramp1_d;
  logic    ch_q, ch_d;
  logic    unused_ext;

  assign unused_ext = ^{ch0_data, ch1_data};
  assign sample_sel = chsel_s ? ramp1_q : ramp0_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ramp0_q <= '0;
      ramp1_q <= '0;
      ch_q    <= 1'b0;
    end else begin
      ramp0_q <= ramp0_d;
      ramp1_q <= ramp1_d;
      ch_q    <= ch_d;
    end
  end

  // Counters advance only on a completed frame, for the channel latched at load
  always_comb begin
    ch_d    = ch_q;
    ramp0_d = ramp0_q;
    ramp1_d = ramp1_q;
    if (load) ch_d = chsel_s;
    if (complete) begin
      if (ch_q) ramp1_d = ramp1_q - Step;
      else      ramp0_d = ramp0_q + Step;
    end
  end
`else
  logic [DATA_W-1:0] unused_ramp_step;
  assign unused_ramp_step = DATA_W'(RAMP_STEP);
  assign sample_sel       = chsel_s ? ch1_data : ch0_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      sdo_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sdo_q   <= sdo_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pden_s) begin
          state_d = PDN;
        end else if (cs_fall) begin
          // A coincident sclk fall is dropped because IDLE never shifts
          load    = 1'b1;
          state_d = SHIFT;
          shreg_d = make_frame(sample_sel);
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (pden_s) begin
          abort   = 1'b1;
          state_d = PDN;
        end else if (cs_rise) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sclk_fall && !cs_s) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (cs_rise) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      PDN: begin
        if (!pden_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sdo_d  = (state_q == SHIFT) ? shreg_q[FRAME_BITS-1] : 1'b0;
    done_d = complete;
    err_d  = abort;
  end

  assign bus.sdo    = sdo_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ad7946_responder.sv
// Bench for ad7946_responder acting as the read controller; honours AD7946_RESP_RAMP_EN when defined.
module tb_ad7946_responder;
  import ad7946_pkg::*;

  localparam int unsigned SS   = 2;
  localparam int          HALF = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] ch0_data, ch1_data;
  logic        frame_done, frame_err;

  ad7946_responder_if bus();

  ad7946_responder #(.SYNC_STAGES(SS), .RAMP_STEP(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .ch0_data(ch0_data),
    .ch1_data(ch1_data),
    .frame_done(frame_done),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int act_done = 0;
  int act_err  = 0;
  int exp_done = 0;
  int exp_err  = 0;
  bit zero_chk = 1'b0;
  logic [13:0] m0 = '0;
  logic [13:0] m1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected sample for a channel from the frame-level rules
  function automatic logic [13:0] model_sample(input bit ch);
`ifdef AD7946_RESP_RAMP_EN
    return ch ? m1 : m0;
`else
    return ch ? ch1_data : ch0_data;
`endif
  endfunction

  task automatic model_complete(input bit ch);
    exp_done++;
    if (ch) m1 = m1 - 14'd1;
    else    m0 = m0 + 14'd1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) act_done++;
      if (frame_err)  act_err++;
      check("done_err_exclusive", 32'(frame_done & frame_err), 0);
      if (zero_chk) check("sdo_quiet", 32'(bus.sdo), 0);
    end
  end

  // Controller side of one frame: nbits sclk cycles then cs_n rise; sdo sampled at each rise
  task automatic run_frame(input bit ch, input int nbits, input bit quiet, output logic [15:0] word);
    bus.chsel = ch;
    wait_clk(2);
    if (!quiet) zero_chk = 1'b0;
    bus.cs_n = 1'b0;
    wait_clk(HALF);
    word = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.sclk = 1'b1;
      word = {word[14:0], bus.sdo};
      wait_clk(HALF);
      bus.sclk = 1'b0;
      wait_clk(HALF);
    end
    bus.cs_n = 1'b1;
    wait_clk(HALF);
    zero_chk = 1'b1;
  endtask

  task automatic do_frame(input bit ch, input int nbits, input string tag);
    logic [15:0] w;
    logic [31:0] expw;
    expw = 32'({2'b00, model_sample(ch)}) >> (16 - nbits);
    run_frame(ch, nbits, 1'b0, w);
    check({tag, "_bits"}, 32'(w), expw);
    if (nbits == 16) model_complete(ch);
    else             exp_err++;
    check({tag, "_done_cnt"}, act_done, exp_done);
    check({tag, "_err_cnt"}, act_err, exp_err);
  endtask

  initial begin
    logic [15:0] w;
    logic [13:0] s;
    bit          ch;
    int          nb;

    rst_n     = 1'b0;
    bus.cs_n  = 1'b1;
    bus.sclk  = 1'b0;
    bus.chsel = 1'b0;
    bus.pden  = 1'b0;
    ch0_data  = '0;
    ch1_data  = '0;
    wait_clk(4);
    check("rst_sdo", 32'(bus.sdo), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    wait_clk(4);
    zero_chk = 1'b1;

    // Hand-computed frames pinning the model
    ch0_data = 14'h2A5B;
    ch1_data = 14'h1FFF;
    run_frame(1'b0, 16, 1'b0, w);
    model_complete(1'b0);
`ifdef AD7946_RESP_RAMP_EN
    check("lit_ch0_first", 32'(w), 32'h0000);
`else
    check("lit_ch0_2A5B", 32'(w), 32'h2A5B);
`endif
    check("lit_done_cnt", act_done, 1);
    run_frame(1'b1, 16, 1'b0, w);
    model_complete(1'b1);
`ifdef AD7946_RESP_RAMP_EN
    check("lit_ch1_first", 32'(w), 32'h0000);
`else
    check("lit_ch1_1FFF", 32'(w), 32'h1FFF);
`endif
    run_frame(1'b1, 16, 1'b0, w);
    model_complete(1'b1);
`ifdef AD7946_RESP_RAMP_EN
    check("lit_ch1_wrap", 32'(w), 32'h3FFF);
`else
    check("lit_ch1_again", 32'(w), 32'h1FFF);
`endif
    run_frame(1'b0, 16, 1'b0, w);
    model_complete(1'b0);
`ifdef AD7946_RESP_RAMP_EN
    check("lit_ch0_second", 32'(w), 32'h0001);
`else
    check("lit_ch0_again", 32'(w), 32'h2A5B);
`endif
    check("lit_err_cnt", act_err, 0);

    do_frame(1'b0, 7, "abort7");
    do_frame(1'b0, 16, "after_abort");

    // Power-down in the middle of a frame
    bus.chsel = 1'b1;
    wait_clk(2);
    zero_chk = 1'b0;
    bus.cs_n = 1'b0;
    wait_clk(HALF);
    repeat (4) begin
      bus.sclk = 1'b1; wait_clk(HALF);
      bus.sclk = 1'b0; wait_clk(HALF);
    end
    bus.pden = 1'b1;
    wait_clk(HALF);
    exp_err++;
    zero_chk = 1'b1;
    check("pden_err_cnt", act_err, exp_err);
    bus.cs_n = 1'b1;
    wait_clk(HALF);
    for (int k = 0; k < 3; k++) begin
      ch = k[0];
      run_frame(ch, 16, 1'b1, w);
      check("pdn_frame_zero", 32'(w), 0);
    end
    check("pdn_done_cnt", act_done, exp_done);
    check("pdn_err_cnt", act_err, exp_err);

    // Frame already low when pden falls must not start
    bus.cs_n = 1'b0;
    wait_clk(HALF);
    bus.pden = 1'b0;
    wait_clk(HALF);
    w = '0;
    for (int i = 0; i < 16; i++) begin
      bus.sclk = 1'b1;
      w = {w[14:0], bus.sdo};
      wait_clk(HALF);
      bus.sclk = 1'b0;
      wait_clk(HALF);
    end
    bus.cs_n = 1'b1;
    wait_clk(HALF);
    check("pending_frame_zero", 32'(w), 0);
    check("pending_done_cnt", act_done, exp_done);
    check("pending_err_cnt", act_err, exp_err);
    do_frame(1'b0, 16, "after_pdn");

    // Reset in the middle of a frame
    ch0_data  = 14'h3FFF;
    bus.chsel = 1'b0;
    s = model_sample(1'b0);
    wait_clk(2);
    zero_chk = 1'b0;
    bus.cs_n = 1'b0;
    wait_clk(HALF);
    repeat (3) begin
      bus.sclk = 1'b1; wait_clk(HALF);
      bus.sclk = 1'b0; wait_clk(HALF);
    end
    check("pre_rst_sdo", 32'(bus.sdo), 32'(s[12]));
    rst_n = 1'b0;
    wait_clk(1);
    check("midrst_sdo", 32'(bus.sdo), 0);
    check("midrst_done", 32'(frame_done), 0);
    check("midrst_err", 32'(frame_err), 0);
    bus.cs_n = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    m0 = '0;
    m1 = '0;
    wait_clk(4);
    zero_chk = 1'b1;
    check("after_rst_err_cnt", act_err, exp_err);
    do_frame(1'b0, 16, "after_rst");

    // Randomized frames: random data, channel and occasional aborts
    for (int i = 0; i < 24; i++) begin
      ch0_data = 14'($urandom);
      ch1_data = 14'($urandom);
      ch       = 1'($urandom);
      nb       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : 16;
      do_frame(ch, nb, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
